adc2fifod: RTL and testbench

- Frame packer between the ADC read stage and the outbound data FIFO (fifod); runs on sys_clk.
- When started by the console, it reads one ADC sample set from the ADC sample buffer and writes a framed byte stream into fifod.
- Output is consumed by the fifod-to-MAC stage as one UDP payload; data_len reports the frame byte count for the UDP length field.

---
 rtl/adc2fifod.sv | 166 ++++++++++++++++
 tb/tb_adc2fifod.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc2fifod.sv
// Frame packer: HEAD0 HEAD1 kind seq, then CHAN_NUM 16-bit samples high byte first; ADC2FIFOD_CSUM_EN appends a checksum.
// Latency: first fifod write is registered 2 cycles after fs rises; unstalled frame is 4+4*CHAN_NUM(+1)+2 cycles.
// Backpressure: fifod_full holds the current write state and its byte, so no byte is lost or duplicated.
module adc2fifod #(
   parameter int unsigned CHAN_NUM = 32,
   parameter logic [7:0]  HEAD0    = 8'h55,
   parameter logic [7:0]  HEAD1    = 8'hAA
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fs,
   output logic        fd,
   input  logic [7:0]  kind_dev,
   output logic [7:0]  adc_rd_addr,
   input  logic [15:0] adc_rd_data,
   input  logic        fifod_full,
   output logic        fifod_txen,
   output logic [7:0]  fifod_txd,
   output logic [11:0] data_len,
   output logic [7:0]  seq
);

   localparam logic [7:0] LAST_ADDR = 8'(CHAN_NUM - 1);
`ifdef ADC2FIFOD_CSUM_EN
   localparam logic [11:0] FRAME_LEN = 12'(4 + 2 * CHAN_NUM + 1);
`else
   localparam logic [11:0] FRAME_LEN = 12'(4 + 2 * CHAN_NUM);
`endif

   typedef enum logic [3:0] {
      IDLE, HD0, HD1, KIND, SEQ, RADR, RWAT, DATH, DATL,
`ifdef ADC2FIFOD_CSUM_EN
      CSUM,
`endif
      DONE
   } state_t;

   state_t      state_q, state_d, wr_next;
   logic        fd_q, fd_d;
   logic        txen_q, txen_d;
   logic [7:0]  txd_q, txd_d;
   logic [7:0]  addr_q, addr_d;
   logic [7:0]  seq_q, seq_d;
   logic [11:0] len_q, len_d;
   logic [7:0]  kind_q, kind_d;
   logic [15:0] sample_q, sample_d;
   logic        wr_req;
   logic [7:0]  wr_byte;
   logic        last_chan;
`ifdef ADC2FIFOD_CSUM_EN
   logic [7:0]  csum_q, csum_d;
`endif

   assign last_chan = (addr_q == LAST_ADDR);

   always_comb begin
      state_d  = state_q;
      fd_d     = fd_q;
      txen_d   = 1'b0;
      txd_d    = txd_q;
      addr_d   = addr_q;
      seq_d    = seq_q;
      len_d    = len_q;
      kind_d   = kind_q;
      sample_d = sample_q;
`ifdef ADC2FIFOD_CSUM_EN
      csum_d   = csum_q;
`endif
      wr_req   = 1'b0;
      wr_byte  = 8'h00;
      wr_next  = state_q;
      case (state_q)
         IDLE: begin
            if (fs) begin
               kind_d  = kind_dev;
               len_d   = FRAME_LEN;
               addr_d  = 8'h00;
`ifdef ADC2FIFOD_CSUM_EN
               csum_d  = 8'h00;
`endif
               state_d = HD0;
            end
         end
         HD0:  begin wr_req = 1'b1; wr_byte = HEAD0;  wr_next = HD1;  end
         HD1:  begin wr_req = 1'b1; wr_byte = HEAD1;  wr_next = KIND; end
         KIND: begin wr_req = 1'b1; wr_byte = kind_q; wr_next = SEQ;  end
         SEQ:  begin wr_req = 1'b1; wr_byte = seq_q;  wr_next = RADR; end
         RADR: state_d = RWAT;
         RWAT: begin
            sample_d = adc_rd_data;
            state_d  = DATH;
         end
         DATH: begin wr_req = 1'b1; wr_byte = sample_q[15:8]; wr_next = DATL; end
         DATL: begin
            wr_req  = 1'b1;
            wr_byte = sample_q[7:0];
`ifdef ADC2FIFOD_CSUM_EN
            wr_next = last_chan ? CSUM : RADR;
`else
            wr_next = last_chan ? DONE : RADR;
`endif
         end
`ifdef ADC2FIFOD_CSUM_EN
         CSUM: begin wr_req = 1'b1; wr_byte = csum_q; wr_next = DONE; end
`endif
         DONE: begin
            // Leaving DONE only on fs low also enforces a fresh fs rise per frame.
            if (!fs) begin
               fd_d    = 1'b0;
               seq_d   = seq_q + 8'd1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (wr_req && !fifod_full) begin
         txen_d  = 1'b1;
         txd_d   = wr_byte;
         state_d = wr_next;
         if (state_q == DATL && !last_chan) addr_d = addr_q + 8'd1;
         if (wr_next == DONE) fd_d = 1'b1;
`ifdef ADC2FIFOD_CSUM_EN
         if (state_q inside {KIND, SEQ, DATH, DATL}) csum_d = csum_q + wr_byte;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         fd_q     <= 1'b0;
         txen_q   <= 1'b0;
         txd_q    <= 8'h00;
         addr_q   <= 8'h00;
         seq_q    <= 8'h00;
         len_q    <= 12'h000;
         kind_q   <= 8'h00;
         sample_q <= 16'h0000;
`ifdef ADC2FIFOD_CSUM_EN
         csum_q   <= 8'h00;
`endif
      end else begin
         state_q  <= state_d;
         fd_q     <= fd_d;
         txen_q   <= txen_d;
         txd_q    <= txd_d;
         addr_q   <= addr_d;
         seq_q    <= seq_d;
         len_q    <= len_d;
         kind_q   <= kind_d;
         sample_q <= sample_d;
`ifdef ADC2FIFOD_CSUM_EN
         csum_q   <= csum_d;
`endif
      end
   end

   assign fd          = fd_q;
   assign fifod_txen  = txen_q;
   assign fifod_txd   = txd_q;
   assign adc_rd_addr = addr_q;
   assign data_len    = len_q;
   assign seq         = seq_q;

endmodule

// File: tb/tb_adc2fifod.sv
// Directed bench for adc2fifod: frame contents, checksum, backpressure, seq wrap, fs drop and mid-frame reset.
module tb_adc2fifod;
   localparam int CH = 32;
`ifdef ADC2FIFOD_CSUM_EN
   localparam int CS = 1;
   localparam logic [7:0] S2_LAST = 8'hC1;
`else
   localparam int CS = 0;
   localparam logic [7:0] S2_LAST = 8'hFF;
`endif
   localparam int FLEN    = 4 + 2 * CH + CS;
   localparam int FD_ITER = 1 + 4 + 4 * CH + CS;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        fs = 1'b0;
   logic        fd;
   logic [7:0]  kind_dev = 8'h00;
   logic [7:0]  adc_rd_addr;
   logic [15:0] adc_rd_data;
   logic        fifod_full = 1'b0;
   logic        fifod_txen;
   logic [7:0]  fifod_txd;
   logic [11:0] data_len;
   logic [7:0]  seq;

   logic [15:0] buffer [0:255];
   logic [7:0]  cap[$];
   logic [7:0]  exp_q[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          bp_viol = 0;
   logic        full_prev = 1'b0;

   adc2fifod dut (
      .clk(clk), .rst_n(rst_n), .fs(fs), .fd(fd), .kind_dev(kind_dev),
      .adc_rd_addr(adc_rd_addr), .adc_rd_data(adc_rd_data),
      .fifod_full(fifod_full), .fifod_txen(fifod_txen), .fifod_txd(fifod_txd),
      .data_len(data_len), .seq(seq)
   );

   always #5 clk = ~clk;

   always @(posedge clk) adc_rd_data <= buffer[adc_rd_addr];

   always @(negedge clk) begin
      if (fifod_txen === 1'b1) begin
         cap.push_back(fifod_txd);
         if (full_prev) bp_viol++;
      end
      full_prev = fifod_full;
   end

   function automatic void build_exp(input logic [7:0] kind, input logic [7:0] sq);
      logic [7:0] s;
      exp_q.delete();
      exp_q.push_back(8'h55);
      exp_q.push_back(8'hAA);
      exp_q.push_back(kind);
      exp_q.push_back(sq);
      s = kind + sq;
      for (int i = 0; i < CH; i++) begin
         exp_q.push_back(buffer[i][15:8]);
         exp_q.push_back(buffer[i][7:0]);
         s = s + buffer[i][15:8] + buffer[i][7:0];
      end
      if (CS == 1) exp_q.push_back(s);
   endfunction

   task automatic fill_ramp();
      for (int i = 0; i < 256; i++) buffer[i] = 16'h0100 + 16'(i);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0; fs = 1'b0; fifod_full = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      cap.delete();
      bp_viol = 0;
   endtask

   // Raises fs and runs until fd is seen (or budget expires); returns one cycle after fd.
   task automatic run_frame(input bit bp, input int drop_after, output int fd_iter, output int first_txen);
      int iter;
      iter = 0; fd_iter = -1; first_txen = -1;
      cap.delete();
      fs = 1'b1;
      while (iter < 3000) begin
         @(posedge clk); #1;
         iter++;
         if (first_txen < 0 && fifod_txen === 1'b1) first_txen = iter;
         if (fd === 1'b1) begin
            fd_iter = iter;
            break;
         end
         if (cap.size() >= drop_after) fs = 1'b0;
         fifod_full = bp ? (iter % 4 != 0) : 1'b0;
      end
      fifod_full = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #2;
      vectors++; if (fd !== 1'b0) begin miscompares++; $display("FAIL rst_fd got %b want 0", fd); end
      vectors++; if (fifod_txen !== 1'b0) begin miscompares++; $display("FAIL rst_txen got %b want 0", fifod_txen); end
      vectors++; if (fifod_txd !== 8'h00) begin miscompares++; $display("FAIL rst_txd got %02h want 00", fifod_txd); end
      vectors++; if (adc_rd_addr !== 8'h00) begin miscompares++; $display("FAIL rst_addr got %02h want 00", adc_rd_addr); end
      vectors++; if (seq !== 8'h00) begin miscompares++; $display("FAIL rst_seq got %02h want 00", seq); end
      vectors++; if (data_len !== 12'h000) begin miscompares++; $display("FAIL rst_len got %0d want 0", data_len); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      vectors++; if (cap.size() != 0 || fifod_txen !== 1'b0) begin
         miscompares++; $display("FAIL rst_idle got %0d writes want 0", cap.size());
      end
   endtask

   task automatic test_frame();
      int fi, ft, first, n;
      fill_ramp(); kind_dev = 8'h6B;
      do_reset();
      run_frame(1'b0, 9999, fi, ft);
      build_exp(8'h6B, 8'h00);
      vectors++; if (ft < 1 || ft > 2) begin miscompares++; $display("FAIL s1_latency got %0d want <=2", ft); end
      vectors++; if (fi != FD_ITER) begin miscompares++; $display("FAIL s1_fd_time got %0d want %0d", fi, FD_ITER); end
      vectors++; if (data_len !== 12'(FLEN)) begin miscompares++; $display("FAIL s1_data_len got %0d want %0d", data_len, FLEN); end
      vectors++; if (cap.size() != FLEN) begin miscompares++; $display("FAIL s1_count got %0d want %0d", cap.size(), FLEN); end
      vectors++; if (cap[4] !== 8'h01 || cap[5] !== 8'h00 || cap[66] !== 8'h01 || cap[67] !== 8'h1F) begin
         miscompares++; $display("FAIL s1_data got %02h %02h .. %02h %02h want 01 00 .. 01 1F", cap[4], cap[5], cap[66], cap[67]);
      end
`ifdef ADC2FIFOD_CSUM_EN
      vectors++; if (cap[68] !== 8'h7B) begin miscompares++; $display("FAIL s1_csum got %02h want 7B", cap[68]); end
`endif
      first = -1;
      foreach (exp_q[i]) if (first < 0 && (i >= cap.size() || cap[i] !== exp_q[i])) first = i;
      vectors++; if (first >= 0) begin
         miscompares++; $display("FAIL s1_bytes idx %0d got %02h want %02h", first, (first < cap.size()) ? cap[first] : 8'h00, exp_q[first]);
      end
      n = cap.size();
      repeat (10) @(posedge clk);
      #1;
      vectors++; if (cap.size() != n || fd !== 1'b1) begin
         miscompares++; $display("FAIL s1_fs_held got writes=%0d fd=%b want writes=%0d fd=1", cap.size(), fd, n);
      end
      fs = 1'b0;
      @(posedge clk); #1;
      vectors++; if (fd !== 1'b0 || seq !== 8'h01) begin
         miscompares++; $display("FAIL s1_done got fd=%b seq=%02h want fd=0 seq=01", fd, seq);
      end
   endtask

   task automatic test_checksum();
      int fi, ft, first;
      for (int i = 0; i < 256; i++) buffer[i] = 16'hFFFF;
      kind_dev = 8'h01;
      do_reset();
      run_frame(1'b0, 9999, fi, ft);
      build_exp(8'h01, 8'h00);
      vectors++; if (cap.size() != FLEN || cap[FLEN-1] !== S2_LAST) begin
         miscompares++; $display("FAIL s2_trailer got %02h (n=%0d) want %02h (n=%0d)", cap[FLEN-1], cap.size(), S2_LAST, FLEN);
      end
      first = -1;
      foreach (exp_q[i]) if (first < 0 && (i >= cap.size() || cap[i] !== exp_q[i])) first = i;
      vectors++; if (first >= 0) begin
         miscompares++; $display("FAIL s2_bytes idx %0d got %02h want %02h", first, (first < cap.size()) ? cap[first] : 8'h00, exp_q[first]);
      end
      fs = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      int fi, ft, first;
      fill_ramp(); kind_dev = 8'h6B;
      do_reset();
      run_frame(1'b1, 9999, fi, ft);
      build_exp(8'h6B, 8'h00);
      vectors++; if (fi <= FD_ITER) begin miscompares++; $display("FAIL s3_stalled got fd at %0d want > %0d", fi, FD_ITER); end
      vectors++; if (bp_viol != 0) begin miscompares++; $display("FAIL s3_txen_full got %0d writes after full want 0", bp_viol); end
      vectors++; if (cap.size() != FLEN) begin miscompares++; $display("FAIL s3_count got %0d want %0d", cap.size(), FLEN); end
      first = -1;
      foreach (exp_q[i]) if (first < 0 && (i >= cap.size() || cap[i] !== exp_q[i])) first = i;
      vectors++; if (first >= 0) begin
         miscompares++; $display("FAIL s3_bytes idx %0d got %02h want %02h", first, (first < cap.size()) ? cap[first] : 8'h00, exp_q[first]);
      end
      fs = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_seq_wrap();
      int fi, ft;
      logic [7:0] want;
      fill_ramp(); kind_dev = 8'h6B;
      do_reset();
      for (int f = 0; f < 257; f++) begin
         want = f[7:0];
         run_frame(1'b0, 9999, fi, ft);
         vectors++; if (cap.size() != FLEN || cap[3] !== want) begin
            miscompares++; $display("FAIL s4_seq frame %0d got %02h want %02h", f, cap[3], want);
         end
         fs = 1'b0;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_fs_drop();
      int fi, ft, first;
      fill_ramp(); kind_dev = 8'h6B;
      do_reset();
      run_frame(1'b0, 10, fi, ft);
      build_exp(8'h6B, 8'h00);
      vectors++; if (fi != FD_ITER) begin miscompares++; $display("FAIL s5_fd_time got %0d want %0d", fi, FD_ITER); end
      vectors++; if (fd !== 1'b0) begin miscompares++; $display("FAIL s5_fd_pulse got %b want 0", fd); end
      first = -1;
      foreach (exp_q[i]) if (first < 0 && (i >= cap.size() || cap[i] !== exp_q[i])) first = i;
      vectors++; if (first >= 0 || cap.size() != FLEN) begin
         miscompares++; $display("FAIL s5_bytes idx %0d n=%0d want n=%0d", first, cap.size(), FLEN);
      end
      repeat (20) @(posedge clk);
      #1;
      vectors++; if (cap.size() != FLEN) begin miscompares++; $display("FAIL s5_no_restart got %0d want %0d", cap.size(), FLEN); end
      run_frame(1'b0, 9999, fi, ft);
      vectors++; if (cap.size() != FLEN || cap[3] !== 8'h01) begin
         miscompares++; $display("FAIL s5_next got seq=%02h n=%0d want seq=01 n=%0d", cap[3], cap.size(), FLEN);
      end
      fs = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_midframe();
      int fi, ft, first;
      bit found;
      fill_ramp(); kind_dev = 8'h6B;
      do_reset();
      run_frame(1'b0, 9999, fi, ft);
      fs = 1'b0;
      @(posedge clk); #1;
      cap.delete();
      fs = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 500 && !found; k++) begin
         @(posedge clk); #1;
         if (adc_rd_addr === 8'd5) found = 1'b1;
      end
      vectors++; if (!found) begin miscompares++; $display("FAIL s6_reach got addr=%02h want 05", adc_rd_addr); end
      repeat (2) @(posedge clk);
      #1;
      vectors++; if (cap.size() != 14) begin miscompares++; $display("FAIL s6_partial got %0d want 14", cap.size()); end
      rst_n = 1'b0;
      #2;
      vectors++; if (fifod_txen !== 1'b0 || fd !== 1'b0 || seq !== 8'h00 || adc_rd_addr !== 8'h00) begin
         miscompares++; $display("FAIL s6_abort got txen=%b fd=%b seq=%02h addr=%02h want 0 0 00 00", fifod_txen, fd, seq, adc_rd_addr);
      end
      fs = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_frame(1'b0, 9999, fi, ft);
      build_exp(8'h6B, 8'h00);
      vectors++; if (cap[0] !== 8'h55 || cap[1] !== 8'hAA) begin
         miscompares++; $display("FAIL s6_head got %02h %02h want 55 AA", cap[0], cap[1]);
      end
      first = -1;
      foreach (exp_q[i]) if (first < 0 && (i >= cap.size() || cap[i] !== exp_q[i])) first = i;
      vectors++; if (first >= 0 || cap.size() != FLEN) begin
         miscompares++; $display("FAIL s6_bytes idx %0d n=%0d want n=%0d", first, cap.size(), FLEN);
      end
      fs = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_frame();
      test_checksum();
      test_backpressure();
      test_seq_wrap();
      test_fs_drop();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
